lc3_mem_arbiter: RTL and testbench

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/lc3_arb_pick.sv | 36 +++
 rtl/lc3_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC-3 memory arbiter slice.
//   LC3_WORD_W  : data/address word width (16)
//   OWNER_CPU   : owner encoding for the control unit (0)
//   OWNER_DMA   : owner encoding for the DMA/IO port (1)
//   arb_state_t : arbiter FSM states IDLE, ACCESS, DONE
// ---------------------------------------------------------------------------
package lc3_pkg;

  localparam int   LC3_WORD_W = 16;
  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lc3_arb_pick.sv
// ---------------------------------------------------------------------------
// lc3_arb_pick
// Combinational two-way pick between the CPU and the DMA port.
// A lone requester always wins. Ties are resolved by the build option:
//   LC3_MEM_ARB_RR_EN defined   : tie goes to whoever is not last_owner
//   LC3_MEM_ARB_RR_EN undefined : tie always goes to the CPU
// Ports:
//   cpu_req, dma_req : request lines
//   last_owner       : previous grant winner (round-robin build only)
//   pick_owner       : OWNER_CPU or OWNER_DMA; only meaningful when a req is high
// ---------------------------------------------------------------------------
module lc3_arb_pick
  import lc3_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
`ifdef LC3_MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic pick_owner
);

  always_comb begin
    pick_owner = OWNER_CPU;
    if (cpu_req && dma_req) begin
`ifdef LC3_MEM_ARB_RR_EN
      pick_owner = (last_owner == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
`else
      pick_owner = OWNER_CPU;
`endif
    end else if (dma_req) begin
      pick_owner = OWNER_DMA;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter
// Arbitrates a single LC-3 memory port between the control unit (CPU) and a
// DMA/IO port. Each transfer runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE
// and back to IDLE, where the next arbitration happens.
// Build option: LC3_MEM_ARB_RR_EN selects round-robin tie breaking
// (otherwise the CPU always wins ties).
// Parameters:
//   WAIT_CYCLES : memory access cycles per transfer, 1..15
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   cpu_req/we/addr/wdata        : CPU request side
//   dma_req/we/addr/wdata        : DMA request side
//   cpu_gnt, dma_gnt             : one-cycle grant pulses
//   cpu_done, dma_done           : one-cycle completion pulses
//   rdata                        : read data, valid with done
//   mem_en, mem_we               : memory enable / write strobe
//   mem_addr, mem_wdata          : latched address / write data
//   mem_rdata                    : memory read data
//   busy                         : high whenever the FSM is not IDLE
//   owner                        : requester of current/last access
// ---------------------------------------------------------------------------
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  dma_req,
  input  logic                  cpu_we,
  input  logic                  dma_we,
  input  logic [LC3_WORD_W-1:0] cpu_addr,
  input  logic [LC3_WORD_W-1:0] cpu_wdata,
  input  logic [LC3_WORD_W-1:0] dma_addr,
  input  logic [LC3_WORD_W-1:0] dma_wdata,
  output logic                  cpu_gnt,
  output logic                  dma_gnt,
  output logic                  cpu_done,
  output logic                  dma_done,
  output logic [LC3_WORD_W-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [LC3_WORD_W-1:0] mem_addr,
  output logic [LC3_WORD_W-1:0] mem_wdata,
  input  logic [LC3_WORD_W-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  // Final count value of the ACCESS phase.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  arb_state_t state;
  logic [3:0] cnt;
  logic       pick_owner;

`ifdef LC3_MEM_ARB_RR_EN
  logic       last_owner;
`endif

  lc3_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
`ifdef LC3_MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .pick_owner (pick_owner)
  );

  assign busy = (state != IDLE);

  // Single FSM block. All port outputs except busy are registered here.
  // mem_we doubles as the latched read/write flag for the transfer, so the
  // ACCESS exit uses it to decide whether to capture read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWNER_CPU;
`ifdef LC3_MEM_ARB_RR_EN
      last_owner <= OWNER_DMA;
`endif
    end else begin
      cpu_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner  <= pick_owner;
            cnt    <= 4'd0;
            mem_en <= 1'b1;
            state  <= ACCESS;
`ifdef LC3_MEM_ARB_RR_EN
            last_owner <= pick_owner;
`endif
            if (pick_owner == OWNER_DMA) begin
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              dma_gnt   <= 1'b1;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              cpu_gnt   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWNER_DMA) begin
              dma_done <= 1'b1;
            end else begin
              cpu_done <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_arbiter
// Self-checking bench for lc3_mem_arbiter. Each transfer is observed over a
// fixed window (arbitration edge through the return to IDLE) and summarised;
// expectations come from a transaction-level model of the arbitration rules
// (lone requester wins, tie policy, last winner, last read data).
// Honours LC3_MEM_ARB_RR_EN for the expected tie policy.
// ---------------------------------------------------------------------------
module tb_lc3_mem_arbiter;

  localparam int W = 2;

`ifdef LC3_MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        cpu_req, dma_req, cpu_we, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_done, dma_done;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state.
  logic        model_last;
  logic [15:0] model_rdata;

  typedef struct {
    int          gnt_cycle;
    int          done_cycle;
    int          cpu_gnts;
    int          dma_gnts;
    int          cpu_dones;
    int          dma_dones;
    int          en_cycles;
    int          we_cycles;
    int          busy_cycles;
    logic [15:0] addr_first;
    logic [15:0] addr_last;
    logic [15:0] wdata_last;
    logic [15:0] rdata_at_done;
    logic        owner_seen;
  } obs_t;

  lc3_mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .cpu_we    (cpu_we),
    .dma_we    (dma_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .cpu_gnt   (cpu_gnt),
    .dma_gnt   (dma_gnt),
    .cpu_done  (cpu_done),
    .dma_done  (dma_done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner of an arbitration: lone requester wins; ties follow the policy.
  function automatic logic model_pick(input logic c, input logic d, input logic last);
    if (c && !d) return 1'b0;
    if (d && !c) return 1'b1;
    if (RR_EN) return ~last;
    return 1'b0;
  endfunction

  task automatic apply_stimulus(input logic c, input logic d,
                                input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
                                input logic dwe, input logic [15:0] daddr, input logic [15:0] dwd,
                                input logic [15:0] mrd);
    cpu_req   = c;
    dma_req   = d;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwd;
    dma_we    = dwe;
    dma_addr  = daddr;
    dma_wdata = dwd;
    mem_rdata = mrd;
  endtask

  // Observes one transfer from the arbitration edge (k=0) through the edge
  // that returns to IDLE (k=W+1). Inputs must be set while IDLE beforehand.
  task automatic observe_access(input bit hold, input bit scramble, output obs_t o);
    o.gnt_cycle = -1; o.done_cycle = -1;
    o.cpu_gnts = 0; o.dma_gnts = 0; o.cpu_dones = 0; o.dma_dones = 0;
    o.en_cycles = 0; o.we_cycles = 0; o.busy_cycles = 0;
    o.addr_first = '0; o.addr_last = '0; o.wdata_last = '0;
    o.rdata_at_done = '0; o.owner_seen = 1'b0;
    for (int k = 0; k <= W + 1; k++) begin
      @(posedge clk); #1;
      if ((cpu_gnt || dma_gnt) && o.gnt_cycle < 0) o.gnt_cycle = k;
      if (cpu_gnt)  o.cpu_gnts++;
      if (dma_gnt)  o.dma_gnts++;
      if (cpu_done) o.cpu_dones++;
      if (dma_done) o.dma_dones++;
      if (cpu_done || dma_done) begin
        o.done_cycle    = k;
        o.rdata_at_done = rdata;
      end
      if (mem_en) begin
        if (o.en_cycles == 0) o.addr_first = mem_addr;
        o.addr_last  = mem_addr;
        o.wdata_last = mem_wdata;
        o.en_cycles++;
      end
      if (mem_we) o.we_cycles++;
      if (busy)   o.busy_cycles++;
      if (k == 0) begin
        o.owner_seen = owner;
        if (!hold) begin
          cpu_req = 1'b0;
          dma_req = 1'b0;
        end
        if (scramble) begin
          cpu_req   = 1'b0;
          cpu_we    = 1'b1;
          cpu_addr  = 16'hFFFF;
          cpu_wdata = 16'h0BAD;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    apply_stimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset mem_en: got %b, want 0", mem_en); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset mem_we: got %b, want 0", mem_we); end
    n_tests++; if ({cpu_gnt, dma_gnt} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset gnt: got %b%b, want 00", cpu_gnt, dma_gnt); end
    n_tests++; if ({cpu_done, dma_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset done: got %b%b, want 00", cpu_done, dma_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b, want 0", busy); end
    n_tests++; if (rdata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset rdata: got %h, want 0000", rdata); end
    n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("[TB] FAIL reset mem_addr: got %h, want 0000", mem_addr); end
    n_tests++; if (mem_wdata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset mem_wdata: got %h, want 0000", mem_wdata); end
    n_tests++; if (owner !== 1'b0) begin n_fail++; $display("[TB] FAIL reset owner: got %b, want 0", owner); end
    @(negedge clk);
    reset_n     = 1'b1;
    model_last  = 1'b1;
    model_rdata = 16'h0;
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++; if ({busy, cpu_gnt, dma_gnt} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset idle_no_req: got %b, want 000", {busy, cpu_gnt, dma_gnt}); end
    end
  endtask

  task automatic test_cpu_read();
    obs_t o;
    apply_stimulus(1, 0, 0, 16'h3000, 16'h0000, 0, 16'h0, 16'h0, 16'hBEEF);
    observe_access(0, 0, o);
    model_last  = 1'b0;
    model_rdata = 16'hBEEF;
    n_tests++; if (o.gnt_cycle !== 0) begin n_fail++; $display("[TB] FAIL cpu_read gnt_cycle: got %0d, want 0", o.gnt_cycle); end
    n_tests++; if (o.done_cycle !== W) begin n_fail++; $display("[TB] FAIL cpu_read done_cycle: got %0d, want %0d", o.done_cycle, W); end
    n_tests++; if (o.cpu_gnts !== 1 || o.dma_gnts !== 0) begin n_fail++; $display("[TB] FAIL cpu_read gnts: got cpu %0d dma %0d, want 1/0", o.cpu_gnts, o.dma_gnts); end
    n_tests++; if (o.cpu_dones !== 1 || o.dma_dones !== 0) begin n_fail++; $display("[TB] FAIL cpu_read dones: got cpu %0d dma %0d, want 1/0", o.cpu_dones, o.dma_dones); end
    n_tests++; if (o.rdata_at_done !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL cpu_read rdata: got %h, want beef", o.rdata_at_done); end
    n_tests++; if (o.we_cycles !== 0) begin n_fail++; $display("[TB] FAIL cpu_read mem_we_cycles: got %0d, want 0", o.we_cycles); end
    n_tests++; if (o.en_cycles !== W) begin n_fail++; $display("[TB] FAIL cpu_read mem_en_cycles: got %0d, want %0d", o.en_cycles, W); end
    n_tests++; if (o.addr_first !== 16'h3000) begin n_fail++; $display("[TB] FAIL cpu_read mem_addr: got %h, want 3000", o.addr_first); end
    n_tests++; if (o.owner_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_read owner: got %b, want 0", o.owner_seen); end
    n_tests++; if (o.busy_cycles !== W + 1) begin n_fail++; $display("[TB] FAIL cpu_read busy_cycles: got %0d, want %0d", o.busy_cycles, W + 1); end
  endtask

  task automatic test_dma_write();
    obs_t o;
    apply_stimulus(0, 1, 0, 16'h0, 16'h0, 1, 16'h00FE, 16'h1234, 16'h5555);
    observe_access(0, 0, o);
    model_last = 1'b1;
    n_tests++; if (o.owner_seen !== 1'b1) begin n_fail++; $display("[TB] FAIL dma_write owner: got %b, want 1", o.owner_seen); end
    n_tests++; if (o.dma_gnts !== 1 || o.cpu_gnts !== 0) begin n_fail++; $display("[TB] FAIL dma_write gnts: got dma %0d cpu %0d, want 1/0", o.dma_gnts, o.cpu_gnts); end
    n_tests++; if (o.dma_dones !== 1 || o.cpu_dones !== 0) begin n_fail++; $display("[TB] FAIL dma_write dones: got dma %0d cpu %0d, want 1/0", o.dma_dones, o.cpu_dones); end
    n_tests++; if (o.en_cycles !== W) begin n_fail++; $display("[TB] FAIL dma_write mem_en_cycles: got %0d, want %0d", o.en_cycles, W); end
    n_tests++; if (o.we_cycles !== W) begin n_fail++; $display("[TB] FAIL dma_write mem_we_cycles: got %0d, want %0d", o.we_cycles, W); end
    n_tests++; if (o.addr_first !== 16'h00FE || o.addr_last !== 16'h00FE) begin n_fail++; $display("[TB] FAIL dma_write mem_addr: got %h/%h, want 00fe", o.addr_first, o.addr_last); end
    n_tests++; if (o.wdata_last !== 16'h1234) begin n_fail++; $display("[TB] FAIL dma_write mem_wdata: got %h, want 1234", o.wdata_last); end
    n_tests++; if (o.rdata_at_done !== model_rdata) begin n_fail++; $display("[TB] FAIL dma_write rdata_hold: got %h, want %h", o.rdata_at_done, model_rdata); end
    n_tests++; if (o.done_cycle !== W) begin n_fail++; $display("[TB] FAIL dma_write done_cycle: got %0d, want %0d", o.done_cycle, W); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic win;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1, 0, 16'h4000 + 16'(i), 16'h0, 0, 16'h8000 + 16'(i), 16'h0, 16'hA000 + 16'(i));
      win = model_pick(1'b1, 1'b1, model_last);
      observe_access(1, 0, o);
      model_last  = win;
      model_rdata = 16'hA000 + 16'(i);
      n_tests++; if (o.owner_seen !== win) begin n_fail++; $display("[TB] FAIL back_to_back owner[%0d]: got %b, want %b", i, o.owner_seen, win); end
      n_tests++; if (o.addr_last !== (win ? 16'h8000 + 16'(i) : 16'h4000 + 16'(i))) begin n_fail++; $display("[TB] FAIL back_to_back mem_addr[%0d]: got %h, want %h", i, o.addr_last, win ? 16'h8000 + 16'(i) : 16'h4000 + 16'(i)); end
      n_tests++; if (o.cpu_gnts + o.dma_gnts !== 1 || o.gnt_cycle !== 0) begin n_fail++; $display("[TB] FAIL back_to_back gnt[%0d]: got %0d pulses at %0d, want 1 at 0", i, o.cpu_gnts + o.dma_gnts, o.gnt_cycle); end
      n_tests++; if (o.rdata_at_done !== model_rdata) begin n_fail++; $display("[TB] FAIL back_to_back rdata[%0d]: got %h, want %h", i, o.rdata_at_done, model_rdata); end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_drop_and_change();
    obs_t o;
    apply_stimulus(1, 0, 0, 16'h1234, 16'h0, 0, 16'h0, 16'h0, 16'hC0DE);
    observe_access(0, 1, o);
    model_last  = 1'b0;
    model_rdata = 16'hC0DE;
    n_tests++; if (o.addr_first !== 16'h1234 || o.addr_last !== 16'h1234) begin n_fail++; $display("[TB] FAIL drop_change mem_addr: got %h/%h, want 1234", o.addr_first, o.addr_last); end
    n_tests++; if (o.we_cycles !== 0) begin n_fail++; $display("[TB] FAIL drop_change mem_we_cycles: got %0d, want 0", o.we_cycles); end
    n_tests++; if (o.cpu_dones !== 1 || o.done_cycle !== W) begin n_fail++; $display("[TB] FAIL drop_change done: got %0d at %0d, want 1 at %0d", o.cpu_dones, o.done_cycle, W); end
    n_tests++; if (o.cpu_gnts !== 1) begin n_fail++; $display("[TB] FAIL drop_change cpu_gnts: got %0d, want 1", o.cpu_gnts); end
    n_tests++; if (o.rdata_at_done !== 16'hC0DE) begin n_fail++; $display("[TB] FAIL drop_change rdata: got %h, want c0de", o.rdata_at_done); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    logic win;
    apply_stimulus(1, 0, 0, 16'h2222, 16'h0, 0, 16'h0, 16'h0, 16'h7777);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (mem_en !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_mid pre_mem_en: got %b, want 1", mem_en); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid mem_en: got %b, want 0", mem_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid busy: got %b, want 0", busy); end
    n_tests++; if (rdata !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_mid rdata: got %h, want 0000", rdata); end
    repeat (2) begin
      @(posedge clk); #1;
      n_tests++; if ({cpu_done, dma_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_mid done: got %b%b, want 00", cpu_done, dma_done); end
    end
    @(negedge clk);
    reset_n     = 1'b1;
    model_last  = 1'b1;
    model_rdata = 16'h0;
    apply_stimulus(1, 1, 1, 16'h0A0A, 16'h1111, 1, 16'h0B0B, 16'h2222, 16'h0);
    win = model_pick(1'b1, 1'b1, model_last);
    observe_access(0, 0, o);
    model_last = win;
    n_tests++; if (o.owner_seen !== 1'b0 || o.cpu_gnts !== 1) begin n_fail++; $display("[TB] FAIL reset_mid tie_after_reset: got owner %b cpu_gnts %0d, want 0/1", o.owner_seen, o.cpu_gnts); end
    n_tests++; if (o.gnt_cycle !== 0) begin n_fail++; $display("[TB] FAIL reset_mid first_arb_cycle: got %0d, want 0", o.gnt_cycle); end
  endtask

  task automatic test_random();
    obs_t o;
    logic        c, d, cwe, dwe, win, exp_we;
    logic [1:0]  r;
    logic [15:0] caddr, cwd, daddr, dwd, mrd, exp_addr, exp_wd;
    int          gap;
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        n_tests++; if ({busy, cpu_gnt, dma_gnt} !== 3'b000) begin n_fail++; $display("[TB] FAIL random idle[%0d]: got %b, want 000", i, {busy, cpu_gnt, dma_gnt}); end
      end
      r     = 2'($urandom_range(1, 3));
      c     = r[0];
      d     = r[1];
      cwe   = 1'($urandom);
      dwe   = 1'($urandom);
      caddr = 16'($urandom);
      cwd   = 16'($urandom);
      daddr = 16'($urandom);
      dwd   = 16'($urandom);
      mrd   = 16'($urandom);
      apply_stimulus(c, d, cwe, caddr, cwd, dwe, daddr, dwd, mrd);
      win      = model_pick(c, d, model_last);
      exp_we   = win ? dwe : cwe;
      exp_addr = win ? daddr : caddr;
      exp_wd   = win ? dwd : cwd;
      observe_access(0, 0, o);
      model_last = win;
      if (!exp_we) model_rdata = mrd;
      n_tests++; if (o.owner_seen !== win) begin n_fail++; $display("[TB] FAIL random owner[%0d]: got %b, want %b", i, o.owner_seen, win); end
      n_tests++; if (o.cpu_gnts !== int'(!win) || o.dma_gnts !== int'(win)) begin n_fail++; $display("[TB] FAIL random gnts[%0d]: got cpu %0d dma %0d, want %0d/%0d", i, o.cpu_gnts, o.dma_gnts, int'(!win), int'(win)); end
      n_tests++; if (o.cpu_dones !== int'(!win) || o.dma_dones !== int'(win)) begin n_fail++; $display("[TB] FAIL random dones[%0d]: got cpu %0d dma %0d, want %0d/%0d", i, o.cpu_dones, o.dma_dones, int'(!win), int'(win)); end
      n_tests++; if (o.gnt_cycle !== 0 || o.done_cycle !== W) begin n_fail++; $display("[TB] FAIL random timing[%0d]: got gnt %0d done %0d, want 0/%0d", i, o.gnt_cycle, o.done_cycle, W); end
      n_tests++; if (o.en_cycles !== W || o.we_cycles !== (exp_we ? W : 0)) begin n_fail++; $display("[TB] FAIL random strobes[%0d]: got en %0d we %0d, want %0d/%0d", i, o.en_cycles, o.we_cycles, W, exp_we ? W : 0); end
      n_tests++; if (o.addr_last !== exp_addr || o.wdata_last !== exp_wd) begin n_fail++; $display("[TB] FAIL random addr_data[%0d]: got %h/%h, want %h/%h", i, o.addr_last, o.wdata_last, exp_addr, exp_wd); end
      n_tests++; if (o.rdata_at_done !== model_rdata) begin n_fail++; $display("[TB] FAIL random rdata[%0d]: got %h, want %h", i, o.rdata_at_done, model_rdata); end
      n_tests++; if (o.busy_cycles !== W + 1) begin n_fail++; $display("[TB] FAIL random busy[%0d]: got %0d, want %0d", i, o.busy_cycles, W + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_drop_and_change();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
